conv_window_sched: RTL and testbench
====================================

# conv_window_sched

Frame-level scheduler for the 3x3 convolution datapath. Accepts a raster-order stream of 4-bit pixels under a valid/ready handshake and holds the two previous image rows in line buffers. It assembles each full 3x3 neighbourhood into the 36-bit `data_in` word and `wr_sig` strobe consumed by the convolution wrapper. It also tags each convolved result with its output-image coordinates and reports frame completion.

## Interface
Parameters:
- `IMG_W`, 16: image width in pixels; must be at least 3.
- `IMG_H`, 16: image height in pixels; must be at least 3.
- `PIX_W`, 4: pixel width in bits.
- `CONV_LAT`, 2: cycles from `win_valid` to the convolved pixel being valid at the wrapper output.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless the state is IDLE.
- `pix_data`  in  PIX_W  input pixel.
- `pix_valid`  in  1  input pixel is valid.
- `pix_ready`  out  1  scheduler can accept a pixel.
- `win_data`  out  9*PIX_W  3x3 window; drives the wrapper's `data_in`.
- `win_valid`  out  1  window strobe; drives the wrapper's `wr_sig`.
- `res_valid`  out  1  wrapper output holds a new result.
- `res_row`  out  clog2(IMG_H)  output-image row of that result.
- `res_col`  out  clog2(IMG_W)  output-image column of that result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle end-of-frame pulse.
- `stall_cnt`  out  16  present only with `CONV_SCHED_PERF_EN`.

## Operation
- States:
  - IDLE: `start` moves to RUN and clears the row and column counters.
  - RUN: the last accepted pixel, at (IMG_H-1, IMG_W-1), moves to DRAIN.
  - DRAIN: waits CONV_LAT cycles, then moves to DONE.
  - DONE: asserts `done` for one cycle, then moves to IDLE.
- `pix_ready` is 1 only in RUN. There is no downstream backpressure because the wrapper always accepts.
- Accept: `pix_valid && pix_ready`. The column counter wraps at IMG_W-1 and the row counter then increments.
- Per accept:
  - Line buffer 1 returns the pixel at (row-1, col); line buffer 0 returns the pixel at (row-2, col).
  - The incoming pixel is written to line buffer 1, and the old line buffer 1 value is written to line buffer 0.
  - Three 3-deep column shift registers, one per row, shift in the new column.
- Window packing: `p[i]` occupies bits [PIX_W*i +: PIX_W], with i = 3*r + c.
  - r=0 is the oldest row; c=0 is the leftmost (oldest) column.
- A window is emitted only when the accepted pixel has row ≥ 2 and col ≥ 2. That gives (IMG_W-2)*(IMG_H-2) windows per frame, with no border padding.
- Coordinates (row-2, col-2) are pushed into a CONV_LAT-deep delay pipe. The pipe output drives `res_valid`, `res_row` and `res_col`.
- Line buffer contents are not reset. The row ≥ 2 gate masks stale data.

## Timing
- Reset values of all outputs are 0, and the state is IDLE.
- Reset asserted mid-frame immediately clears the state, counters, delay pipe and outputs.
- `win_valid` and `win_data` are registered: high for exactly the one cycle after the accepting edge.
- `res_valid` follows `win_valid` by exactly CONV_LAT cycles, with matching coordinates.
- With `pix_valid` held high, one window is emitted per cycle within a row. There is no window at row wrap.
- `pix_valid` low in RUN freezes the counters and shift registers. Window emission pauses with no loss.
- `done` is asserted the cycle after the final `res_valid`.
- `start` during RUN, DRAIN or DONE is ignored.
- A `start` asserted in the same cycle as `done` is also ignored, because the state is not yet IDLE.

## Configuration
- With `CONV_SCHED_PERF_EN`:
  - `stall_cnt` exists and counts RUN cycles with `pix_valid` low.
  - It saturates at 16'hFFFF and clears on an accepted `start`.
- Without `CONV_SCHED_PERF_EN`: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `conv_pkg`:
  - `PIX_W`, and the window width `WIN_W = 9*PIX_W`.
  - The state enum {IDLE, RUN, DRAIN, DONE}.
  - A `win_t` packed array of 9 pixels.
- Sub-module `line_buffer`: IMG_W-deep, PIX_W-wide, one read and one write at the same address per accept, read-before-write. It is instantiated twice.

## Test plan
- IMG_W=IMG_H=4, pixel k = k mod 16, `pix_valid` held high:
  - Window 0 appears the cycle after pixel 10 is accepted, with `win_data`=36'hA98654210.
  - Exactly 4 windows are emitted, with `res` coordinates (0,0), (0,1), (1,0), (1,1).
  - `done` pulses once.
- Same stream with `pix_valid` low for 3 cycles after pixel 5 → identical window values and count, each window delayed 3 cycles; with PERF_EN, `stall_cnt`=3.
- CONV_LAT=2: `res_valid` is high exactly 2 cycles after each `win_valid`, and `done` is high 3 cycles after the last `win_valid`.
- `reset` asserted after pixel 9 → all outputs 0 and state IDLE. A new `start` with a full frame then yields correct windows, with no stale-row window before row 2.
- `start` pulsed during RUN and again during DRAIN → ignored: the counters are unchanged and the frame completes normally.
- IMG_W=3, IMG_H=3 → exactly one window, at pixel 8, with `res` coordinates (0,0).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution scheduler: pixel/window widths,
// scheduler state encoding and the packed 9-pixel window type.
package conv_pkg;
  localparam int PIX_W = 4;
  localparam int WIN_W = 9 * PIX_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef logic [8:0][PIX_W-1:0] win_t;
endpackage

// File: rtl/conv_window_sched_line_buffer.sv
// One image row of storage; combinational read and write share the column
// address, so a read in the accepting cycle returns the value from one row earlier.
module line_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/conv_window_sched.sv
// Raster-to-3x3-window scheduler feeding the convolution wrapper.
// Optional stall counter port enabled by defining CONV_SCHED_PERF_EN.
module conv_window_sched #(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int PIX_W    = 4,
  parameter int CONV_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [9*PIX_W-1:0]       win_data,
  output logic                     win_valid,
  output logic                     res_valid,
  output logic [$clog2(IMG_H)-1:0] res_row,
  output logic [$clog2(IMG_W)-1:0] res_col,
  output logic                     busy,
  output logic                     done
`ifdef CONV_SCHED_PERF_EN
  , output logic [15:0]            stall_cnt
`endif
);
  import conv_pkg::*;

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int DW = $clog2(CONV_LAT + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  state_e                        state_q, state_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [CW-1:0]                 col_q, col_d;
  logic [DW-1:0]                 drain_q, drain_d;
  logic [2:0][1:0][PIX_W-1:0]    h_q, h_d;
  logic [8:0][PIX_W-1:0]         win_q, win_d;
  logic [CONV_LAT:0]             vld_pipe_q, vld_pipe_d;
  logic [CONV_LAT:0][RW-1:0]     rowp_q, rowp_d;
  logic [CONV_LAT:0][CW-1:0]     colp_q, colp_d;
  logic                          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0]                   stall_q, stall_d;
`endif

  logic                  accept;
  logic [PIX_W-1:0]      rd1, rd0;
  logic [2:0][PIX_W-1:0] nxt;

  assign accept = pix_valid && ready_q;
  // Newest column entering each window row; row 0 is the oldest image row.
  assign nxt    = {pix_data, rd1, rd0};

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(pix_data), .rdata(rd1)
  );
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(rd1), .rdata(rd0)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    drain_d    = drain_q;
    h_d        = h_q;
    win_d      = win_q;
    vld_pipe_d = {vld_pipe_q[CONV_LAT-1:0], 1'b0};
    rowp_d     = {rowp_q[CONV_LAT-1:0], {RW{1'b0}}};
    colp_d     = {colp_q[CONV_LAT-1:0], {CW{1'b0}}};
`ifdef CONV_SCHED_PERF_EN
    stall_d    = stall_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        row_d   = '0;
        col_d   = '0;
`ifdef CONV_SCHED_PERF_EN
        stall_d = '0;
`endif
      end
      RUN: if (accept) begin
        for (int r = 0; r < 3; r++) h_d[r] = {nxt[r], h_q[r][1]};
        if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
          for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = h_q[r][0];
            win_d[3*r+1] = h_q[r][1];
            win_d[3*r+2] = nxt[r];
          end
          vld_pipe_d[0] = 1'b1;
          rowp_d[0]     = row_q - ROW_TWO;
          colp_d[0]     = col_q - COL_TWO;
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
`ifdef CONV_SCHED_PERF_EN
      else if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
`endif
      // One extra cycle past CONV_LAT lets the final result leave the pipe first.
      DRAIN: if (drain_q == DW'(CONV_LAT)) state_d = DONE;
             else drain_d = drain_q + DW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      drain_q    <= '0;
      h_q        <= '0;
      win_q      <= '0;
      vld_pipe_q <= '0;
      rowp_q     <= '0;
      colp_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      drain_q    <= drain_d;
      h_q        <= h_d;
      win_q      <= win_d;
      vld_pipe_q <= vld_pipe_d;
      rowp_q     <= rowp_d;
      colp_q     <= colp_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CONV_SCHED_PERF_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign pix_ready = ready_q;
  assign win_data  = win_q;
  assign win_valid = vld_pipe_q[0];
  assign res_valid = vld_pipe_q[CONV_LAT];
  assign res_row   = rowp_q[CONV_LAT];
  assign res_col   = colp_q[CONV_LAT];
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CONV_SCHED_PERF_EN
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: a cycle-indexed expectation model built from
// the image contents, plus literal pins on window values, timing and coordinates.
module tb_conv_window_sched;
  localparam int W = 4, H = 4, LAT = 2;

  logic clk = 0, reset = 0, start = 0, pix_valid = 0;
  logic [3:0]  pix_data = '0;
  logic        pix_ready, win_valid, res_valid, busy, done;
  logic [35:0] win_data;
  logic [1:0]  res_row, res_col;

  logic        start3 = 0, pv3 = 0;
  logic [3:0]  pd3 = '0;
  logic        pix_ready3, win_valid3, res_valid3, busy3, done3;
  logic [35:0] win_data3;
  logic [1:0]  res_row3, res_col3;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0] stall_cnt, stall_cnt3;
`endif

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .CONV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_data(win_data), .win_valid(win_valid), .res_valid(res_valid),
    .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
`ifdef CONV_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  conv_window_sched #(.IMG_W(3), .IMG_H(3), .PIX_W(4), .CONV_LAT(LAT)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .pix_data(pd3), .pix_valid(pv3),
    .pix_ready(pix_ready3), .win_data(win_data3), .win_valid(win_valid3), .res_valid(res_valid3),
    .res_row(res_row3), .res_col(res_col3), .busy(busy3), .done(done3)
`ifdef CONV_SCHED_PERF_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, cur_seed = 0, f_start = 0;
  bit m_ready = 0, m_busy = 0, m_idle = 1;
  int m_k = 0;
  bit          e_wv [64];
  bit          e_rv [64];
  bit          e_dn [64];
  logic [35:0] e_wd [64];
  int          e_rr [64];
  int          e_rc [64];

  int          win_off[$];
  logic [3:0]  rcoord[$];
  logic [35:0] first_win;
  int          dn_n, dn_off;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] pix_of(input int s, input int k);
    return 4'((k + s) % 16);
  endfunction

  // Window p[3r+c] is image pixel (row-2+r, col-2+c).
  function automatic logic [35:0] model_win(input int s, input int row, input int col);
    logic [35:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[4*(3*r+c) +: 4] = pix_of(s, (row - 2 + r) * W + (col - 2 + c));
    return w;
  endfunction

  // Expectation model: schedules outputs at absolute cycle numbers.
  initial begin
    int e, row, col, n;
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int i = 0; i < 64; i++) begin e_wv[i] = 0; e_rv[i] = 0; e_dn[i] = 0; end
        m_ready = 0; m_busy = 0; m_idle = 1; m_k = 0;
      end else begin
        e = cyc % 64;
        if (start && m_idle) begin
          m_idle = 0; m_busy = 1; m_ready = 1; m_k = 0; f_start = cyc;
        end else if (m_ready && pix_valid) begin
          row = m_k / W; col = m_k % W;
          if (row >= 2 && col >= 2) begin
            n = (cyc + 1) % 64;
            e_wv[n] = 1; e_wd[n] = model_win(cur_seed, row, col);
            n = (cyc + 1 + LAT) % 64;
            e_rv[n] = 1; e_rr[n] = row - 2; e_rc[n] = col - 2;
          end
          if (m_k == W*H - 1) begin
            m_ready = 0;
            e_dn[(cyc + 2 + LAT) % 64] = 1;
          end
          m_k++;
        end
        if (e_dn[e]) begin m_busy = 0; m_idle = 1; end
        e_wv[e] = 0; e_rv[e] = 0; e_dn[e] = 0;
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, plus event recording for literal pins.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        e = cyc % 64;
        if (!reset) begin
          chk("rst_pix_ready", pix_ready, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_win_valid", win_valid, 0);
          chk("rst_res_valid", res_valid, 0);
        end else begin
          chk("pix_ready", pix_ready, m_ready);
          chk("busy", busy, m_busy);
          chk("done", done, e_dn[e]);
          chk("win_valid", win_valid, e_wv[e]);
          if (e_wv[e] && win_valid) chk("win_data", win_data, e_wd[e]);
          chk("res_valid", res_valid, e_rv[e]);
          if (e_rv[e] && res_valid) begin
            chk("res_row", res_row, e_rr[e]);
            chk("res_col", res_col, e_rc[e]);
          end
          if (win_valid) begin
            if (win_off.size() == 0) first_win = win_data;
            win_off.push_back(cyc - f_start);
          end
          if (res_valid) rcoord.push_back({res_row, res_col});
          if (done) begin dn_n++; dn_off = cyc - f_start; end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    pix_data = pix_of(cur_seed, m_k);
  endtask

  task automatic run_frame(input int s, input bit stall, input bit glitch);
    int g = 0;
    bit st = 0, g1 = 0, g2 = 0, g3 = 0;
    cur_seed = s;
    win_off.delete(); rcoord.delete(); dn_n = 0; first_win = '0;
    tick(); start = 1; pix_valid = 1;
    tick(); start = 0;
    while (m_busy && g < 300) begin
      if (stall && !st && m_k == 6) begin
        pix_valid = 0; repeat (3) tick(); pix_valid = 1; st = 1;
      end else if (glitch && !g1 && m_k == 3) begin
        start = 1; tick(); start = 0; g1 = 1;
      end else if (glitch && !g2 && m_k == W*H && !e_dn[cyc % 64]) begin
        start = 1; tick(); start = 0; g2 = 1;
      end else if (glitch && !g3 && e_dn[cyc % 64]) begin
        start = 1; tick(); start = 0; g3 = 1;
      end else tick();
      g++;
    end
    chk("frame_in_budget", g < 300, 1);
    pix_valid = 0;
    repeat (3) tick();
  endtask

  task automatic check_coords();
    logic [15:0] packed_c = '0;
    for (int i = 0; i < rcoord.size(); i++) packed_c = {packed_c[11:0], rcoord[i]};
    chk("res_count", rcoord.size(), 4);
    chk("res_coords", packed_c, 16'h0145);
  endtask

  initial begin
    int k3, acc, nw3, wk3, dn3;
    logic [35:0] w3;
    logic [3:0]  c3;
    repeat (3) @(negedge clk);
    chk("reset_win_data", win_data, 0);
    chk("reset_busy", busy, 0);
    #2 reset = 1;
    tick();
    chk("idle_ready", pix_ready, 0);

    // Continuous stream
    run_frame(0, 0, 0);
    chk("model_win0", model_win(0, 2, 2), 36'hA98654210);
    chk("win_count", win_off.size(), 4);
    chk("win0_value", first_win, 36'hA98654210);
    chk("win0_offset", win_off[0], 12);
    chk("win1_offset", win_off[1], 13);
    chk("win3_offset", win_off[3], 17);
    chk("done_count", dn_n, 1);
    chk("done_offset", dn_off, 20);
    check_coords();

    // Three idle input cycles after pixel 5
    run_frame(0, 1, 0);
    chk("stall_win_count", win_off.size(), 4);
    chk("stall_win0_value", first_win, 36'hA98654210);
    chk("stall_win0_offset", win_off[0], 15);
    chk("stall_win3_offset", win_off[3], 20);
    chk("stall_done_offset", dn_off, 23);
    check_coords();
`ifdef CONV_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt, 3);
`endif

    // Reset after pixel 9, then a fresh frame with different contents
    cur_seed = 0;
    tick(); start = 1; pix_valid = 1;
    tick(); start = 0;
    for (int g = 0; g < 40 && m_k < 10; g++) tick();
    #2 reset = 0;
    #1;
    chk("midrst_win_valid", win_valid, 0);
    chk("midrst_win_data", win_data, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pix_ready, 0);
    chk("midrst_done", done, 0);
    tick(); tick();
    #2 reset = 1;
    pix_valid = 0;
    tick();
    run_frame(9, 0, 0);
    chk("post_rst_win_count", win_off.size(), 4);
    chk("post_rst_win0", first_win, 36'h321FEDBA9);
    chk("post_rst_win0_offset", win_off[0], 12);
    chk("post_rst_done", dn_n, 1);

    // start pulses in RUN, DRAIN and the done cycle are ignored
    run_frame(0, 0, 1);
    chk("glitch_win_count", win_off.size(), 4);
    chk("glitch_win0", first_win, 36'hA98654210);
    chk("glitch_done_count", dn_n, 1);
    chk("glitch_done_offset", dn_off, 20);
    chk("glitch_idle_busy", busy, 0);
    check_coords();
`ifdef CONV_SCHED_PERF_EN
    chk("glitch_stall_cnt", stall_cnt, 0);
`endif

    // Minimum 3x3 image
    k3 = 0; acc = 0; nw3 = 0; wk3 = 0; dn3 = 0; w3 = '0; c3 = 4'hF;
    pv3 = 1;
    @(negedge clk); start3 = 1;
    @(negedge clk); start3 = 0;
    repeat (30) begin
      k3 += acc;
      pd3 = 4'(k3);
      if (win_valid3) begin nw3++; w3 = win_data3; wk3 = k3; end
      if (res_valid3) c3 = {res_row3, res_col3};
      if (done3) dn3++;
      acc = (pix_ready3 && pv3) ? 1 : 0;
      @(negedge clk);
    end
    pv3 = 0;
    chk("img3_win_count", nw3, 1);
    chk("img3_win_value", w3, 36'h876543210);
    chk("img3_win_after_pixels", wk3, 9);
    chk("img3_res_coord", c3, 4'h0);
    chk("img3_done_count", dn3, 1);
    chk("img3_idle", busy3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
